// File: rtl/uart_alu_intf_pkg.sv
// uart_alu_intf_pkg: shared FSM state encoding and ALU opcode constants
package uart_alu_intf_pkg;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND_LO,
        WAIT_TX_LO,
        SEND_HI,
        WAIT_TX_HI
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_intf_timeout.sv
// intf_timeout: idle-cycle counter between operand bytes, flags expiry on its last allowed cycle
module intf_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d   = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counter register; cleared on accepted bytes, advances while waiting for operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_alu_intf.sv
// uart_alu_intf: collects A, B, opcode bytes from UART, sends the ALU result back as two bytes
module uart_alu_intf
    import uart_alu_intf_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_CODE        = 6,
    parameter int NB_DATA_OUT    = 9,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    input  logic [NB_DATA_OUT-1:0] i_alu_result,
    input  logic                   i_tx_done,
    output logic [NB_DATA-1:0]     o_a,
    output logic [NB_DATA-1:0]     o_b,
    output logic [NB_CODE-1:0]     o_op,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_timeout
);

    state_t                 state_q;
    logic [NB_DATA-1:0]     a_q;
    logic [NB_DATA-1:0]     b_q;
    logic [NB_CODE-1:0]     op_q;
    logic [NB_DATA-1:0]     tx_data_q;
    logic [NB_DATA_OUT-1:0] res_q;
    logic                   tx_start_q;
    logic                   timeout_q;
    logic                   rx_state;
    logic                   accept;
    logic                   cnt_en;
    logic                   expired;

    assign rx_state = (state_q == WAIT_A) || (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign accept   = i_rx_done && rx_state;
    assign cnt_en   = (state_q == WAIT_B) || (state_q == WAIT_OP);

    intf_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_reset),
        .clear  (accept),
        .enable (cnt_en),
        .expired(expired)
    );

    // Frame FSM: operand capture, result latch, two-byte transmit with registered strobes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            res_q      <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                WAIT_A: if (i_rx_done) begin
                    a_q     <= i_rx_data;
                    state_q <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    b_q     <= i_rx_data;
                    state_q <= WAIT_OP;
                end else if (expired) begin
                    state_q   <= WAIT_A;
                    timeout_q <= 1'b1;
                end
                WAIT_OP: if (i_rx_done) begin
                    op_q    <= i_rx_data[NB_CODE-1:0];
                    state_q <= SEND_LO;
                end else if (expired) begin
                    state_q   <= WAIT_A;
                    timeout_q <= 1'b1;
                end
                SEND_LO: begin
                    res_q      <= i_alu_result;
                    tx_data_q  <= i_alu_result[NB_DATA-1:0];
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT_TX_LO;
                end
                WAIT_TX_LO: if (i_tx_done) state_q <= SEND_HI;
                SEND_HI: begin
                    tx_data_q  <= {{(2*NB_DATA-NB_DATA_OUT){1'b0}}, res_q[NB_DATA_OUT-1:NB_DATA]};
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT_TX_HI;
                end
                WAIT_TX_HI: if (i_tx_done) state_q <= WAIT_A;
                default: state_q <= WAIT_A;
            endcase
        end
    end

    assign o_a        = a_q;
    assign o_b        = b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = state_q != WAIT_A;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// tb_uart_alu_intf: randomized frame-level check of uart_alu_intf against an ALU/frame reference model
module tb_uart_alu_intf;
    import uart_alu_intf_pkg::*;

    localparam int T = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic [8:0] alu_res;
    logic       tx_done = 1'b0;
    logic [7:0] a, b, tx_data;
    logic [5:0] op;
    logic       tx_start, busy, timeout;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [5:0] OPS [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    always #5 clk = ~clk;

    uart_alu_intf #(
        .NB_DATA(8), .NB_CODE(6), .NB_DATA_OUT(9), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_res), .i_tx_done(tx_done),
        .o_a(a), .o_b(b), .o_op(op), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout)
    );

    function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        logic [8:0] r;
        r = '0;
        case (c)
            OP_ADD: r = {1'b0, x} + {1'b0, y};
            OP_SUB: r = {1'b0, x} - {1'b0, y};
            OP_AND: r = {1'b0, x & y};
            OP_OR:  r = {1'b0, x | y};
            OP_XOR: r = {1'b0, x ^ y};
            OP_NOR: r = {1'b0, ~(x | y)};
            OP_SRA: r = 9'($signed({x[7], x}) >>> y);
            OP_SRL: r = {1'b0, x >> y};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb alu_res = alu_f(a, b, op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (!tx_start && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(tx_start), 1);
    endtask

    task automatic run_frame(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] opb,
                             input int gb, input int go, input bit inject);
        logic [8:0] r;
        r = alu_f(a0, b0, opb[5:0]);
        pulse_rx(a0);
        idle(gb);
        pulse_rx(b0);
        idle(go);
        pulse_rx(opb);
        chk("op_reg", 32'(op), 32'(opb[5:0]));
        chk("early", 32'(tx_start), 0);
        chk("busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat", 32'(tx_start), 1);
        chk("lo", 32'(tx_data), 32'(r[7:0]));
        @(negedge clk);
        chk("pulse1", 32'(tx_start), 0);
        if (inject) begin
            pulse_rx(8'hAA);
            chk("inj_data", 32'(tx_data), 32'(r[7:0]));
            chk("inj_a", 32'(a), 32'(a0));
            chk("inj_start", 32'(tx_start), 0);
        end
        idle($urandom_range(0, 3));
        pulse_tx();
        wait_start("hi");
        chk("hi", 32'(tx_data), 32'({7'b0, r[8]}));
        chk("b_hold", 32'(b), 32'(b0));
        @(negedge clk);
        chk("pulse2", 32'(tx_start), 0);
        idle($urandom_range(0, 3));
        pulse_tx();
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic timeout_case(input int nb);
        int tpos, ntout, starts;
        tpos = -1;
        ntout = 0;
        starts = 0;
        pulse_rx(8'h0F);
        if (nb > 1) pulse_rx(8'hF0);
        for (int i = 1; i <= T + 4; i++) begin
            @(negedge clk);
            if (timeout) begin
                if (tpos < 0) tpos = i;
                ntout++;
            end
            if (tx_start) starts++;
        end
        chk("tout_pos", 32'(tpos), 32'(T));
        chk("tout_cnt", 32'(ntout), 1);
        chk("tout_starts", 32'(starts), 0);
        chk("tout_busy", 32'(busy), 0);
        chk("tout_a", 32'(a), 32'h0F);
        if (nb > 1) chk("tout_b", 32'(b), 32'hF0);
    endtask

    initial begin
        int starts;
        logic [7:0] opb;
        logic [1:0] up;
        idle(2);
        chk("rst_a", 32'(a), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tout", 32'(timeout), 0);
        rst = 1'b0;
        idle(1);

        pulse_tx();
        idle(2);
        chk("spur_tx_busy", 32'(busy), 0);
        chk("spur_tx_start", 32'(tx_start), 0);

        run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
        run_frame(8'hFF, 8'h01, 8'h20, 1, 2, 0);
        run_frame(8'h03, 8'h05, 8'h22, 0, 0, 1);
        run_frame(8'h81, 8'h02, {2'b11, OP_SRA}, T - 1, T - 1, 0);

        timeout_case(2);
        timeout_case(1);

        pulse_rx(8'h05);
        pulse_rx(8'h03);
        pulse_rx(8'h20);
        idle(2);
        pulse_tx();
        wait_start("rst_hi");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", 32'(a), 0);
        chk("arst_b", 32'(b), 0);
        chk("arst_op", 32'(op), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start) starts++;
        end
        chk("arst_no_start", 32'(starts), 0);
        run_frame(8'h02, 8'h02, 8'h24, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            up  = 2'($urandom_range(0, 3));
            opb = {up, OPS[$urandom_range(0, 7)]};
            run_frame(8'($urandom), 8'($urandom), opb,
                      ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, 4)),
                      ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, 4)),
                      bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
